// File: rtl/bf_pkg.sv
// Shared definitions for the Bellman-Ford arbitrage engine.
//   NODES     vertex count (adjmat is NODES x NODES)
//   PRED_W    vertex index width
//   WEIGHT_W  signed edge/vertex weight width
//   TIMEOUT   watchdog limit, in cycles, for the relax/detect wait states
//   vert_word_t    one vertmat entry: {predecessor, weight}
//   sched_state_t  scheduler FSM states
package bf_pkg;

    localparam int NODES    = 16;
    localparam int PRED_W   = 4;
    localparam int WEIGHT_W = 32;
    localparam int TIMEOUT  = 4096;

    typedef struct packed {
        logic [PRED_W-1:0]          pred;
        logic signed [WEIGHT_W-1:0] weight;
    } vert_word_t;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WRITE        = 3'd1,
        S_INIT         = 3'd2,
        S_RELAX_START  = 3'd3,
        S_RELAX_WAIT   = 3'd4,
        S_DETECT_RESET = 3'd5,
        S_DETECT_WAIT  = 3'd6,
        S_FINISH       = 3'd7
    } sched_state_t;

endpackage

// File: rtl/bf_watchdog.sv
// Cycle watchdog for the scheduler wait states.
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   clr_i     synchronous clear of the count (has priority over en_i)
//   en_i      count one cycle
//   expire_o  high in the TIMEOUT-th enabled cycle since the last clear
module bf_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CNT_W-1:0] count_q;

    // The count holds the number of enabled cycles already elapsed, so the
    // enabled cycle that sees TIMEOUT-1 is the TIMEOUT-th one.
    assign expire_o = en_i && (count_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && !expire_o) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bf_scheduler.sv
// Top-level sequencer for the Bellman-Ford arbitrage engine.
// Accepts host edge-weight updates (one adjmat write each); an update flagged
// last starts a solve: vertmat init {v,0} for every vertex, up to NODES-1
// relax passes (early exit when a pass changes nothing), then one
// negative-cycle detect sweep. A watchdog aborts a stuck wait.
// Ports:
//   clk, reset                   clock / asynchronous active-high reset
//   upd_valid/upd_ready          host update handshake, ready only in IDLE
//   upd_row/col/weight/last      update fields; last starts a solve
//   adjmat_we/wr_row/wr_col/wr_data   adjmat write port
//   vertmat_we/wr_addr/wr_data        vertmat write port ({pred, weight})
//   relax_start/relax_done/relax_changed  relax engine handshake
//   cycle_reset/cycle_done        cycle detector control / completion level
//   busy, run_done, pass_count, err_timeout   status
//   dbg_state                     current FSM state
// Handshake: an update transfers on a rising edge where upd_valid and
// upd_ready are both high; the host holds the fields stable until then.
// All outputs are registered and decoded from the next state, so each one
// lines up with the state it belongs to.
module bf_scheduler
    import bf_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [PRED_W-1:0]          upd_row,
    input  logic [PRED_W-1:0]          upd_col,
    input  logic [WEIGHT_W-1:0]        upd_weight,
    input  logic                       upd_last,
    output logic                       adjmat_we,
    output logic [PRED_W-1:0]          adjmat_wr_row,
    output logic [PRED_W-1:0]          adjmat_wr_col,
    output logic [WEIGHT_W-1:0]        adjmat_wr_data,
    output logic                       vertmat_we,
    output logic [PRED_W-1:0]          vertmat_wr_addr,
    output logic [PRED_W+WEIGHT_W-1:0] vertmat_wr_data,
    output logic                       relax_start,
    input  logic                       relax_done,
    input  logic                       relax_changed,
    output logic                       cycle_reset,
    input  logic                       cycle_done,
    output logic                       busy,
    output logic                       run_done,
    output logic [PRED_W-1:0]          pass_count,
    output logic                       err_timeout,
    output logic [2:0]                 dbg_state
);

    sched_state_t        state_q, state_d;
    logic [PRED_W-1:0]   v_q, v_d;
    logic [PRED_W-1:0]   p_q, p_d;
    logic                last_q;
    logic                accept;
    logic                abort;
    logic                wd_clr;
    logic                wd_en;
    logic                wd_expire;
    vert_word_t          vert_d;

    logic                upd_ready_q;
    logic                adj_we_q;
    logic [PRED_W-1:0]   adj_row_q;
    logic [PRED_W-1:0]   adj_col_q;
    logic [WEIGHT_W-1:0] adj_data_q;
    logic                vert_we_q;
    logic [PRED_W-1:0]   vert_addr_q;
    vert_word_t          vert_data_q;
    logic                relax_start_q;
    logic                cycle_reset_q;
    logic                busy_q;
    logic                run_done_q;
    logic [PRED_W-1:0]   pass_count_q;
    logic                err_q;

    bf_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_i    (reset),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        p_d     = p_q;
        accept  = 1'b0;
        abort   = 1'b0;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (upd_valid && upd_ready_q) begin
                    accept  = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_q) begin
                    state_d = S_INIT;
                    v_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (v_q == PRED_W'(NODES - 1)) begin
                    state_d = S_RELAX_START;
                    p_d     = '0;
                end else begin
                    v_d = v_q + PRED_W'(1);
                end
            end
            S_RELAX_START: begin
                wd_clr  = 1'b1;
                state_d = S_RELAX_WAIT;
            end
            S_RELAX_WAIT: begin
                wd_en = 1'b1;
                if (relax_done) begin
                    p_d = p_q + PRED_W'(1);
                    // NODES-1 passes are enough for any shortest path; the
                    // pass that brings p to NODES-1 is the last one.
                    if (!relax_changed || (p_q == PRED_W'(NODES - 2))) begin
                        state_d = S_DETECT_RESET;
                    end else begin
                        state_d = S_RELAX_START;
                    end
                end else if (wd_expire) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DETECT_RESET: begin
                wd_clr  = 1'b1;
                state_d = S_DETECT_WAIT;
            end
            S_DETECT_WAIT: begin
                wd_en = 1'b1;
                if (cycle_done) begin
                    state_d = S_FINISH;
                end else if (wd_expire) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        vert_d.pred   = v_d;
        vert_d.weight = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            v_q           <= '0;
            p_q           <= '0;
            last_q        <= 1'b0;
            upd_ready_q   <= 1'b1;
            adj_we_q      <= 1'b0;
            adj_row_q     <= '0;
            adj_col_q     <= '0;
            adj_data_q    <= '0;
            vert_we_q     <= 1'b0;
            vert_addr_q   <= '0;
            vert_data_q   <= '0;
            relax_start_q <= 1'b0;
            cycle_reset_q <= 1'b1;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
            pass_count_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            p_q     <= p_d;
            if (accept) begin
                last_q     <= upd_last;
                adj_row_q  <= upd_row;
                adj_col_q  <= upd_col;
                adj_data_q <= upd_weight;
            end
            upd_ready_q   <= (state_d == S_IDLE);
            adj_we_q      <= (state_d == S_WRITE);
            vert_we_q     <= (state_d == S_INIT);
            vert_addr_q   <= v_d;
            vert_data_q   <= vert_d;
            relax_start_q <= (state_d == S_RELAX_START);
            // An abort also pulses the detector reset so a half-finished
            // sweep cannot leave a stale cycle_done behind.
            cycle_reset_q <= (state_d == S_DETECT_RESET) || abort;
            busy_q        <= (state_d != S_IDLE);
            run_done_q    <= (state_d == S_FINISH);
            if (state_d == S_FINISH) begin
                pass_count_q <= p_d;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign upd_ready       = upd_ready_q;
    assign adjmat_we       = adj_we_q;
    assign adjmat_wr_row   = adj_row_q;
    assign adjmat_wr_col   = adj_col_q;
    assign adjmat_wr_data  = adj_data_q;
    assign vertmat_we      = vert_we_q;
    assign vertmat_wr_addr = vert_addr_q;
    assign vertmat_wr_data = vert_data_q;
    assign relax_start     = relax_start_q;
    assign cycle_reset     = cycle_reset_q;
    assign busy            = busy_q;
    assign run_done        = run_done_q;
    assign pass_count      = pass_count_q;
    assign err_timeout     = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_bf_scheduler.sv
module tb_bf_scheduler;
    import bf_pkg::*;

    logic        clk;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  upd_row;
    logic [3:0]  upd_col;
    logic [31:0] upd_weight;
    logic        upd_last;
    logic        adjmat_we;
    logic [3:0]  adjmat_wr_row;
    logic [3:0]  adjmat_wr_col;
    logic [31:0] adjmat_wr_data;
    logic        vertmat_we;
    logic [3:0]  vertmat_wr_addr;
    logic [35:0] vertmat_wr_data;
    logic        relax_start;
    logic        relax_done;
    logic        relax_changed;
    logic        cycle_reset;
    logic        cycle_done;
    logic        busy;
    logic        run_done;
    logic [3:0]  pass_count;
    logic        err_timeout;
    logic [2:0]  dbg_state;

    bf_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .upd_valid       (upd_valid),
        .upd_ready       (upd_ready),
        .upd_row         (upd_row),
        .upd_col         (upd_col),
        .upd_weight      (upd_weight),
        .upd_last        (upd_last),
        .adjmat_we       (adjmat_we),
        .adjmat_wr_row   (adjmat_wr_row),
        .adjmat_wr_col   (adjmat_wr_col),
        .adjmat_wr_data  (adjmat_wr_data),
        .vertmat_we      (vertmat_we),
        .vertmat_wr_addr (vertmat_wr_addr),
        .vertmat_wr_data (vertmat_wr_data),
        .relax_start     (relax_start),
        .relax_done      (relax_done),
        .relax_changed   (relax_changed),
        .cycle_reset     (cycle_reset),
        .cycle_done      (cycle_done),
        .busy            (busy),
        .run_done        (run_done),
        .pass_count      (pass_count),
        .err_timeout     (err_timeout),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [39:0] exp_adj_q[$];
    logic [39:0] exp_vert_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    int rs_cnt = 0, rd_cnt = 0, adj_cnt = 0;
    int last_rs_cyc = 0, last_rd_cyc = 0, last_adj_cyc = 0;
    int last_done_cyc = 0, detect_cyc = 0;
    int first_vert_cyc = 0, init_len = 0;
    logic prev_vw = 1'b0;
    logic rdy_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- relax engine / cycle detector models ----------------
    int relax_delay = 2;
    int changed_at  = 0;   // 0: every pass reports a change
    int done_idx    = 0;
    logic mute      = 1'b0;

    initial begin
        int pend;
        pend = 0;
        relax_done = 1'b0;
        relax_changed = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            relax_done = 1'b0;
            relax_changed = 1'b0;
            if (reset) begin
                pend = 0;
            end else if (relax_start && !mute) begin
                pend = relax_delay;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    done_idx++;
                    relax_done = 1'b1;
                    relax_changed = !(changed_at != 0 && done_idx == changed_at);
                    last_done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        logic cr;
        int dcnt;
        dcnt = 0;
        cycle_done = 1'b0;
        forever begin
            @(negedge clk);
            cr = cycle_reset;
            @(posedge clk);
            #1;
            if (cr) begin
                cycle_done = 1'b0;
                dcnt = 0;
            end else if (dcnt < 3) begin
                dcnt++;
            end else begin
                cycle_done = 1'b1;
            end
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [39:0] e;
        if (!reset) begin
            if (adjmat_we) begin
                adj_cnt++;
                last_adj_cyc = cyc;
                if (exp_adj_q.size() == 0) chk("adj_unexpected_write", 64'd1, 64'd0);
                else begin
                    e = exp_adj_q.pop_front();
                    chk("adj_write", 64'({adjmat_wr_row, adjmat_wr_col, adjmat_wr_data}), 64'(e));
                end
            end
            if (vertmat_we) begin
                if (!prev_vw) first_vert_cyc = cyc;
                if (exp_vert_q.size() == 0) chk("vert_unexpected_write", 64'd1, 64'd0);
                else begin
                    e = exp_vert_q.pop_front();
                    chk("vert_write", 64'({vertmat_wr_addr, vertmat_wr_data}), 64'(e));
                end
            end
            if (relax_start) begin
                rs_cnt++;
                if (prev_vw) init_len = cyc - first_vert_cyc;
                last_rs_cyc = cyc;
            end
            if (run_done) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (cycle_reset && busy) detect_cyc = cyc;
            if (upd_ready && busy) rdy_busy = 1'b1;
            prev_vw = vertmat_we;
        end else begin
            prev_vw = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_upd(input logic [3:0] r, input logic [3:0] c,
                            input logic [31:0] w, input logic l);
        int n;
        logic acc;
        upd_row = r;
        upd_col = c;
        upd_weight = w;
        upd_last = l;
        upd_valid = 1'b1;
        exp_adj_q.push_back({r, c, w});
        if (l) begin
            for (int v = 0; v < 16; v++) exp_vert_q.push_back({4'(v), 4'(v), 32'd0});
        end
        acc = 1'b0;
        n = 0;
        while (!acc && n < 3000) begin
            acc = upd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        upd_valid = 1'b0;
        if (!acc) chk("upd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_run(input int rd0);
        int n;
        n = 0;
        while (rd_cnt == rd0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_check(input string tag, input logic [3:0] r, input logic [3:0] c,
                             input logic [31:0] w, input int ch_at, input int dly,
                             input logic [3:0] exp_p);
        int rs0, rd0;
        changed_at = ch_at;
        relax_delay = dly;
        done_idx = 0;
        rs0 = rs_cnt;
        rd0 = rd_cnt;
        send_upd(r, c, w, 1'b1);
        wait_run(rd0);
        chk({tag, "_run_done_pulses"}, 64'(rd_cnt - rd0), 64'd1);
        chk({tag, "_pass_count"}, 64'(pass_count), 64'(exp_p));
        chk({tag, "_relax_start_pulses"}, 64'(rs_cnt - rs0), 64'(exp_p));
        chk({tag, "_detect_latency"}, 64'(detect_cyc - last_done_cyc), 64'd1);
        chk({tag, "_init_cycles"}, 64'(init_len), 64'd16);
        step(1);
        chk({tag, "_idle_busy_ready"}, 64'({busy, upd_ready}), 64'b01);
        chk({tag, "_queues_drained"}, 64'(exp_adj_q.size() + exp_vert_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [31:0] w;
        int          changed_at;
        int          delay;
        logic [3:0]  exp_pass;
    } vec_t;

    vec_t vecs[5];

    // ---------------- test sequence ----------------
    initial begin
        int rd0, rs0, n, t_err;

        vecs[0] = '{4'd2,  4'd3,  32'hFFFF_FFFB, 0,  2, 4'd15};
        vecs[1] = '{4'd1,  4'd4,  32'd7,         3,  3, 4'd3};
        vecs[2] = '{4'd0,  4'd0,  32'd100,       1,  1, 4'd1};
        vecs[3] = '{4'd15, 4'd15, 32'hFFFF_FFFF, 14, 2, 4'd14};
        vecs[4] = '{4'd9,  4'd6,  32'h7FFF_FFFF, 15, 1, 4'd15};

        reset = 1'b0;
        upd_valid = 1'b0;
        upd_row = '0;
        upd_col = '0;
        upd_weight = '0;
        upd_last = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("reset_handshake", 64'({upd_ready, cycle_reset, busy}), 64'b110);
        chk("reset_strobes", 64'({adjmat_we, vertmat_we, relax_start, run_done}), 64'd0);
        chk("reset_status", 64'({pass_count, err_timeout}), 64'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        step(1);

        // Main function across distinct update/relax patterns.
        for (int i = 0; i < 5; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].w,
                      vecs[i].changed_at, vecs[i].delay, vecs[i].exp_pass);
        end

        // Batch of updates: only the last one starts a solve.
        send_upd(4'd3, 4'd7, 32'd11, 1'b0);
        step(2);
        chk("batch_idle_after_nonlast", 64'({busy, vertmat_we}), 64'd0);
        send_upd(4'd4, 4'd8, 32'hFFFF_FFFE, 1'b0);
        step(2);
        run_check("batch", 4'd5, 4'd9, 32'd3, 2, 2, 4'd2);

        // relax_done and a stale cycle_done while idle must be ignored.
        rs0 = rs_cnt;
        @(posedge clk);
        #2;
        relax_done = 1'b1;
        relax_changed = 1'b1;
        step(3);
        chk("spurious_done_idle", 64'({busy, 4'(rs_cnt - rs0)}), 64'd0);

        // Update held by the host during a solve stalls until IDLE.
        changed_at = 0;
        relax_delay = 2;
        done_idx = 0;
        rd0 = rd_cnt;
        rdy_busy = 1'b0;
        send_upd(4'd8, 4'd1, 32'd55, 1'b1);
        send_upd(4'd6, 4'd2, 32'd42, 1'b0);
        step(2);
        chk("hold_run_done", 64'(rd_cnt - rd0), 64'd1);
        chk("hold_pass_count", 64'(pass_count), 64'd15);
        chk("hold_write_after_finish", 64'(last_adj_cyc > last_rd_cyc), 64'd1);
        chk("hold_ready_while_busy", 64'(rdy_busy), 64'd0);
        chk("hold_queues_drained", 64'(exp_adj_q.size() + exp_vert_q.size()), 64'd0);

        // relax_done withheld: watchdog abort after TIMEOUT wait cycles.
        mute = 1'b1;
        rd0 = rd_cnt;
        send_upd(4'd1, 4'd2, 32'd3, 1'b1);
        n = 0;
        while (!err_timeout && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
        t_err = cyc;
        chk("timeout_err", 64'(err_timeout), 64'd1);
        chk("timeout_latency", 64'(t_err - last_rs_cyc), 64'd4097);
        chk("timeout_state", 64'(dbg_state), 64'(S_IDLE));
        chk("timeout_outputs", 64'({busy, upd_ready, cycle_reset}), 64'b011);
        mute = 1'b0;
        step(20);
        chk("timeout_no_run_done", 64'(rd_cnt - rd0), 64'd0);
        chk("timeout_queues_drained", 64'(exp_adj_q.size() + exp_vert_q.size()), 64'd0);
        run_check("after_timeout", 4'd10, 4'd11, 32'd9, 2, 2, 4'd2);
        chk("err_sticky", 64'(err_timeout), 64'd1);

        // Asynchronous reset in the middle of RELAX_WAIT.
        changed_at = 0;
        relax_delay = 8;
        done_idx = 0;
        rs0 = rs_cnt;
        send_upd(4'd7, 4'd7, 32'hFFFF_FFF7, 1'b1);
        n = 0;
        while (rs_cnt == rs0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        step(3);
        chk("pre_reset_in_wait", 64'(dbg_state), 64'(S_RELAX_WAIT));
        #2 reset = 1'b1;
        #1;
        chk("midreset_handshake", 64'({upd_ready, cycle_reset, busy}), 64'b110);
        chk("midreset_status", 64'({pass_count, err_timeout, relax_start, run_done, vertmat_we}), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        step(2);
        run_check("after_reset", 4'd12, 4'd13, 32'd21, 4, 2, 4'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
